// File: rtl/sdr_system_wrapper.sv
// sdr_system_wrapper: register-mapped SDR capture (8-channel RX NCO tagging, boxcar waterfalls, pop-on-read FIFOs); macro SDR_WF1_EN adds the second waterfall
module sdr_system_wrapper #(
    parameter int FIFO_DEPTH = 16,
    parameter int RX_DECIM   = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] adc_dat_a_i,
    input  logic        wr_en,
    input  logic [8:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [8:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid
);
`ifdef SDR_WF1_EN
    localparam int NW = 2;
`else
    localparam int NW = 1;
`endif
    localparam int NF = NW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    logic [6:0]          wa, ra;
    logic [3:0]          ctrl_q;
    logic [31:0]         rx_freq_q [8];
    logic [31:0]         wf_freq_q [NW];
    logic [31:0]         wf_decim_q [NW];
    logic [29:0]         rx_phase_q [8];
    logic [29:0]         rx_phase_d [8];
    logic [31:0]         rx_div_q, rx_div_d;
    logic [2:0]          rx_ch_q, rx_ch_d;
    logic                rx_tick;
    logic [NF-1:0]       push, fifo_ovf;
    logic [NF-1:0][31:0] word, fifo_rdata;
    logic [NF-1:0][15:0] fifo_cnt;
    logic [31:0]         rd_d;
    logic                unused_ok;

    assign wa = wr_addr[8:2];
    assign ra = rd_addr[8:2];
    assign unused_ok = ^{wr_addr[1:0], rd_addr[1:0], ctrl_q};

    // register file writes; read-only and unmapped addresses fall through untouched
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ctrl_q     <= '0;
            rx_freq_q  <= '{default: '0};
            wf_freq_q  <= '{default: '0};
            wf_decim_q <= '{default: '0};
        end else if (wr_en) begin
            if (wa == 7'h00) ctrl_q <= wr_data[3:0];
            for (int n = 0; n < 8; n++) if (wa == 7'(1 + n)) rx_freq_q[n] <= wr_data;
            for (int n = 0; n < NW; n++) begin
                if (wa == 7'(9 + 2 * n)) wf_freq_q[n] <= wr_data;
                if (wa == 7'(10 + 2 * n)) wf_decim_q[n] <= wr_data;
            end
        end
    end

    // RX next state: per-channel NCOs, decimation counter and channel rotation, all forced to 0 when stopped
    always_comb begin
        rx_tick  = ctrl_q[0] && rx_div_q >= 32'(RX_DECIM - 1);
        rx_div_d = (!ctrl_q[0] || rx_tick) ? 32'd0 : rx_div_q + 32'd1;
        rx_ch_d  = ctrl_q[0] ? rx_ch_q + 3'(rx_tick) : 3'd0;
        for (int n = 0; n < 8; n++) rx_phase_d[n] = ctrl_q[0] ? rx_phase_q[n] + rx_freq_q[n][29:0] : 30'd0;
    end

    assign push[0] = rx_tick && ctrl_q[3];
    assign word[0] = {rx_ch_q, rx_phase_q[rx_ch_q][29:17], adc_dat_a_i};

    // RX state registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rx_phase_q <= '{default: '0};
            rx_div_q   <= '0;
            rx_ch_q    <= '0;
        end else begin
            rx_phase_q <= rx_phase_d;
            rx_div_q   <= rx_div_d;
            rx_ch_q    <= rx_ch_d;
        end
    end

    for (genvar w = 0; w < NW; w++) begin : g_wf
        logic [29:0] phase_q, phase_d;
        logic [31:0] sum_q, sum_d, acc;
        logic [15:0] cnt_q, cnt_d, last;
        logic        run, tick, unused_ok;
        // boxcar: the D-th sample closes the word, the following sample starts a fresh sum
        always_comb begin
            run     = ctrl_q[1 + w];
            last    = (wf_decim_q[w][15:0] < 16'd2) ? 16'd1 : wf_decim_q[w][15:0] - 16'd1;
            acc     = sum_q + {{16{adc_dat_a_i[15]}}, adc_dat_a_i};
            tick    = run && cnt_q >= last;
            phase_d = run ? phase_q + wf_freq_q[w][29:0] : 30'd0;
            sum_d   = (run && !tick) ? acc : 32'd0;
            cnt_d   = (run && !tick) ? cnt_q + 16'd1 : 16'd0;
        end
        // waterfall state registers
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                phase_q <= '0;
                sum_q   <= '0;
                cnt_q   <= '0;
            end else begin
                phase_q <= phase_d;
                sum_q   <= sum_d;
                cnt_q   <= cnt_d;
            end
        end
        assign push[1 + w] = tick && ctrl_q[3];
        assign word[1 + w] = acc;
        assign unused_ok   = ^phase_q;
    end

    for (genvar f = 0; f < NF; f++) begin : g_fifo
        logic [31:0]   mem_q [FIFO_DEPTH];
        logic [AW-1:0] wp_q, rp_q;
        logic [AW:0]   cnt_q;
        logic          ovf_q, pop, do_push, do_pop;
        assign pop            = rd_en && ra == 7'(68 + f);
        assign do_pop         = pop && cnt_q != '0;
        assign do_push        = push[f] && (cnt_q != FULL || do_pop);
        assign fifo_rdata[f]  = (cnt_q == '0) ? 32'd0 : mem_q[rp_q];
        assign fifo_cnt[f]    = 16'(cnt_q);
        assign fifo_ovf[f]    = ovf_q;
        // storage write port
        always_ff @(posedge aclk) if (do_push) mem_q[wp_q] <= word[f];
        // pointers and count; reset or fifo_run low empties the queue and drops the sticky overflow
        always_ff @(posedge aclk) begin
            if (!aresetn || !ctrl_q[3]) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                wp_q  <= wp_q + AW'(do_push);
                rp_q  <= rp_q + AW'(do_pop);
                cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
                if (push[f] && !do_push) ovf_q <= 1'b1;
            end
        end
    end

    // read mux on the word index; anything unmapped reads 0
    always_comb begin
        rd_d = 32'd0;
        if (ra == 7'h00) rd_d = {28'd0, ctrl_q};
        for (int n = 0; n < 8; n++) if (ra == 7'(1 + n)) rd_d = rx_freq_q[n];
        for (int n = 0; n < NW; n++) begin
            if (ra == 7'(9 + 2 * n)) rd_d = wf_freq_q[n];
            if (ra == 7'(10 + 2 * n)) rd_d = wf_decim_q[n];
        end
        for (int n = 0; n < NF; n++) begin
            if (ra == 7'(64 + n)) rd_d = {fifo_ovf[n], 15'd0, fifo_cnt[n]};
            if (ra == 7'(68 + n)) rd_d = fifo_rdata[n];
        end
    end

    // registered read response, one cycle after the request
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_data  <= rd_d;
            rd_valid <= rd_en;
        end
    end
endmodule

// File: tb/tb_sdr_system_wrapper.sv
// tb_sdr_system_wrapper: scoreboard bench for the sdr_system_wrapper register map, RX/WF paths and FIFO limits
module tb_sdr_system_wrapper;
    logic        aclk, aresetn, wr_en, rd_en, rd_valid, sine_mode;
    logic [15:0] adc_dat_a_i, adc_const;
    logic [8:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data, d;
    logic [31:0] sb_q [$];
    int          checks = 0, failures = 0, cyc = 0, c0, n;

    sdr_system_wrapper #(.FIFO_DEPTH(16), .RX_DECIM(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .adc_dat_a_i(adc_dat_a_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    function automatic logic [15:0] sine(input int c);
        case (c % 10)
            1, 4:    return 16'd9630;
            2, 3:    return 16'd15582;
            6, 9:    return 16'hDA62;
            7, 8:    return 16'hC322;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [31:0] rx_word(input int k, input int c);
        int t = 16 * k + 15;
        logic [63:0] ph;
        ph = (64'(t) * 64'h0A3D_70A3) & 64'h3FFF_FFFF;
        return {3'(k % 8), (k % 8 == 1) ? ph[29:17] : 13'd0, sine(c + 1 + t)};
    endfunction

    initial forever begin
        @(negedge aclk);
        adc_dat_a_i = sine_mode ? sine(cyc) : adc_const;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] v);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        @(negedge aclk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a, output logic [31:0] v);
        rd_en = 1'b1; rd_addr = a;
        @(negedge aclk);
        rd_en = 1'b0;
        check("rd_valid", 32'(rd_valid), 32'd1);
        v = rd_data;
    endtask

    task automatic pop_chk(input logic [8:0] a, input string tag);
        logic [31:0] v, e;
        e = 32'hDEAD_BEEF;
        if (sb_q.size() != 0) e = sb_q.pop_front();
        rd(a, v);
        check(tag, v, e);
    endtask

    task automatic do_reset();
        logic [31:0] v;
        aresetn = 1'b0; wr_en = 1'b1; wr_addr = 9'h000; wr_data = 32'hF; rd_en = 1'b1; rd_addr = 9'h000;
        repeat (3) @(negedge aclk);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        aresetn = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        sb_q.delete();
        rd(9'h000, v); check("rst_ctrl", v, 32'd0);
        rd(9'h024, v); check("rst_wf0_freq", v, 32'd0);
        rd(9'h100, v); check("rst_rx_cnt", v, 32'd0);
    endtask

    initial begin
        aresetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        sine_mode = 1'b0; adc_const = 16'd0; adc_dat_a_i = 16'd0;
        do_reset();

        wr(9'h008, 32'h1234_5678); rd(9'h008, d); check("rx_freq1_rb", d, 32'h1234_5678);
        wr(9'h020, 32'hCAFE_F00D); rd(9'h020, d); check("rx_freq7_rb", d, 32'hCAFE_F00D);
        wr(9'h028, 32'h0001_0008); rd(9'h028, d); check("wf0_decim_rb", d, 32'h0001_0008);
        wr(9'h000, 32'hFFFF_FFF5); rd(9'h002, d); check("ctrl_mask", d, 32'h0000_0005);
        wr(9'h100, 32'h0000_1234); rd(9'h100, d); check("ro_cnt_write", d, 32'd0);
        wr(9'h1FC, 32'h0000_0055); rd(9'h1FC, d); check("unmapped", d, 32'd0);

        do_reset();
        sine_mode = 1'b1;
        wr(9'h008, 32'h0A3D_70A3);
        c0 = cyc;
        wr(9'h000, 32'hF);
        for (int k = 0; k < 16; k++) sb_q.push_back(rx_word(k, c0));
        repeat (10000) @(negedge aclk);
        wr(9'h000, 32'h8);
        rd(9'h100, d); check("rx_cnt_full", d, 32'h8000_0010);
        for (int k = 0; k < 16; k++) pop_chk(9'h110, "rx_word");
        sb_q.push_back(32'd0); pop_chk(9'h110, "rx_empty_pop");
        rd(9'h100, d); check("rx_cnt_empty", d, 32'h8000_0000);
        wr(9'h000, 32'hF);
        repeat (50) @(negedge aclk);
        wr(9'h000, 32'h7);
        repeat (3) @(negedge aclk);
        rd(9'h100, d); check("fifo_off_rx_cnt", d, 32'd0);
        rd(9'h104, d); check("fifo_off_wf0_cnt", d, 32'd0);
        rd(9'h108, d); check("fifo_off_wf1_cnt", d, 32'd0);

        do_reset();
        sine_mode = 1'b0; adc_const = 16'd3;
        wr(9'h024, 32'h1EB8_51EB); rd(9'h024, d); check("wf0_freq_rb", d, 32'h1EB8_51EB);
        wr(9'h028, 32'd8); rd(9'h028, d); check("wf0_decim8_rb", d, 32'd8);
        c0 = cyc;
        wr(9'h000, 32'hA);
        for (int i = 0; i < 40; i++) begin
            n = (cyc < c0 + 9) ? 0 : (cyc - c0 - 9) / 8 + 1;
            rd(9'h104, d); check("wf0_cnt_step", d, 32'(n));
        end
        while (cyc < c0 + 9 + 8 * 17) @(negedge aclk);
        while ((cyc + 1 - c0 - 9) % 8 != 0) @(negedge aclk);
        sb_q.push_back(32'd24); pop_chk(9'h114, "wf0_word_pushpop");
        rd(9'h104, d); check("wf0_cnt_pushpop", d, 32'h8000_0010);
        wr(9'h000, 32'h8);
        rd(9'h104, d); check("wf0_cnt_stopped", d, 32'h8000_0010);
        for (int k = 0; k < 16; k++) sb_q.push_back(32'd24);
        for (int k = 0; k < 16; k++) pop_chk(9'h114, "wf0_word");
        rd(9'h104, d); check("wf0_cnt_drained", d, 32'h8000_0000);
        sb_q.push_back(32'd0); pop_chk(9'h114, "wf0_empty_pop");
        rd(9'h104, d); check("wf0_cnt_after_empty", d, 32'h8000_0000);

        do_reset();
        adc_const = 16'hFFFF;
        repeat (2) @(negedge aclk);
        wr(9'h028, 32'd1);
        wr(9'h030, 32'd16);
        wr(9'h02C, 32'h1234_5678);
        wr(9'h000, 32'hE);
        repeat (100) @(negedge aclk);
        wr(9'h000, 32'h8);
        sb_q.push_back(32'hFFFF_FFFE); pop_chk(9'h114, "wf0_decim1_word");
`ifdef SDR_WF1_EN
        rd(9'h030, d); check("wf1_decim_rb", d, 32'd16);
        rd(9'h02C, d); check("wf1_freq_rb", d, 32'h1234_5678);
        sb_q.push_back(32'hFFFF_FFF0); pop_chk(9'h118, "wf1_word");
`else
        rd(9'h030, d); check("wf1_decim_absent", d, 32'd0);
        rd(9'h02C, d); check("wf1_freq_absent", d, 32'd0);
        rd(9'h108, d); check("wf1_cnt_absent", d, 32'd0);
        sb_q.push_back(32'd0); pop_chk(9'h118, "wf1_pop_absent");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
